rs485_tx_arbiter: RTL and testbench

RS485_TX_ARBITER -- requirements
Module: rs485_tx_arbiter

---
 rtl/rs485_tx_arbiter.sv | 171 +++++++++++++++++
 tb/tb_rs485_tx_arbiter.sv | 343 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rs485_tx_arbiter.sv
// Four-requester round-robin arbiter in front of one RS-485 transmitter.
// Ports: clk, reset (async, active-low); req/req_data from requesters;
// tx_busy/tx_byte_idx from the transmitter; tx_rq/tx_data/byte_sel to it;
// grant (one-hot owner), done (per-owner completion pulse), err (timeout).
// Optional macro RS485_TX_ARBITER_TIMEOUT_EN bounds the START wait.
module rs485_tx_arbiter #(
  parameter int GAP_CYCLES     = 64,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  req,
  input  logic [31:0] req_data,
  input  logic        tx_busy,
  input  logic [2:0]  tx_byte_idx,
  output logic        tx_rq,
  output logic [7:0]  tx_data,
  output logic [2:0]  byte_sel,
  output logic [3:0]  grant,
  output logic [3:0]  done,
  output logic        err
);

  localparam bit PARAMS_OK =
    (GAP_CYCLES >= 1) && (GAP_CYCLES <= 255) &&
    (TIMEOUT_CYCLES >= 1) && (TIMEOUT_CYCLES <= 255);

  // An out-of-range setting shows up as this block in the hierarchy.
  if (!PARAMS_OK) begin : g_param_out_of_range
  end

  localparam logic [7:0] GAP_LAST = 8'(GAP_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    SEND  = 2'd2,
    GAP   = 2'd3
  } state_e;

  state_e      state_q;
  logic        busy_s1_q;
  logic        busy_s2_q;
  logic [3:0]  grant_q;
  logic [1:0]  last_q;
  logic        tx_rq_q;
  logic [3:0]  done_q;
  logic [7:0]  gap_q;

  logic        pick_vld_d;
  logic [1:0]  pick_idx_d;
  logic [3:0]  pick_oh_d;
  logic [1:0]  cand;

  // Round-robin: scan last+1, last+2, ... wrapping mod 4.
  always_comb begin
    pick_vld_d = 1'b0;
    pick_idx_d = last_q;
    cand       = last_q;
    for (int k = 1; k <= 4; k++) begin
      cand = last_q + 2'(k);
      if (!pick_vld_d && req[cand]) begin
        pick_vld_d = 1'b1;
        pick_idx_d = cand;
      end
    end
    pick_oh_d = 4'b0001 << pick_idx_d;
  end

`ifdef RS485_TX_ARBITER_TIMEOUT_EN
  localparam logic [7:0] TO_LAST =
    8'(TIMEOUT_CYCLES - 1);
  logic [7:0] to_q;
  logic       err_q;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      busy_s1_q <= 1'b0;
      busy_s2_q <= 1'b0;
      grant_q   <= 4'b0000;
      last_q    <= 2'd3;
      tx_rq_q   <= 1'b0;
      done_q    <= 4'b0000;
      gap_q     <= 8'd0;
`ifdef RS485_TX_ARBITER_TIMEOUT_EN
      to_q      <= 8'd0;
      err_q     <= 1'b0;
`endif
    end else begin
      busy_s1_q <= tx_busy;
      busy_s2_q <= busy_s1_q;
      done_q    <= 4'b0000;
`ifdef RS485_TX_ARBITER_TIMEOUT_EN
      err_q     <= 1'b0;
`endif
      unique case (state_q)
        IDLE: begin
          if (pick_vld_d) begin
            grant_q <= pick_oh_d;
            last_q  <= pick_idx_d;
            tx_rq_q <= 1'b1;
            state_q <= START;
`ifdef RS485_TX_ARBITER_TIMEOUT_EN
            to_q    <= 8'd0;
`endif
          end
        end
        START: begin
          if (busy_s2_q) begin
            state_q <= SEND;
`ifdef RS485_TX_ARBITER_TIMEOUT_EN
          end else if (to_q == TO_LAST) begin
            tx_rq_q <= 1'b0;
            err_q   <= 1'b1;
            done_q  <= grant_q;
            grant_q <= 4'b0000;
            gap_q   <= 8'd0;
            state_q <= GAP;
          end else begin
            to_q    <= to_q + 8'd1;
`endif
          end
        end
        SEND: begin
          // SEND is only entered with busy high, so low here
          // is the falling edge that ends the frame.
          if (!busy_s2_q) begin
            tx_rq_q <= 1'b0;
            done_q  <= grant_q;
            grant_q <= 4'b0000;
            gap_q   <= 8'd0;
            state_q <= GAP;
          end
        end
        GAP: begin
          if (gap_q == GAP_LAST) begin
            state_q <= IDLE;
          end else begin
            gap_q <= gap_q + 8'd1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  always_comb begin
    tx_data = 8'h00;
    unique case (1'b1)
      grant_q[0]: tx_data = req_data[7:0];
      grant_q[1]: tx_data = req_data[15:8];
      grant_q[2]: tx_data = req_data[23:16];
      grant_q[3]: tx_data = req_data[31:24];
      default:    tx_data = 8'h00;
    endcase
  end

  assign byte_sel = tx_byte_idx;
  assign grant    = grant_q;
  assign tx_rq    = tx_rq_q;
  assign done     = done_q;

`ifdef RS485_TX_ARBITER_TIMEOUT_EN
  assign err = err_q;
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_rs485_tx_arbiter.sv
// Self-checking bench for rs485_tx_arbiter: table vectors for the
// data path, directed corner sequences and randomized traffic vs model.
module tb_rs485_tx_arbiter;

  localparam int GAP = 64;
  localparam int TMO = 255;

  logic        clk;
  logic        reset;
  logic [3:0]  req;
  logic [31:0] req_data;
  logic        tx_busy;
  logic [2:0]  tx_byte_idx;
  logic        tx_rq;
  logic [7:0]  tx_data;
  logic [2:0]  byte_sel;
  logic [3:0]  grant;
  logic [3:0]  done;
  logic        err;

  rs485_tx_arbiter #(
    .GAP_CYCLES(GAP),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk(clk),
    .reset(reset),
    .req(req),
    .req_data(req_data),
    .tx_busy(tx_busy),
    .tx_byte_idx(tx_byte_idx),
    .tx_rq(tx_rq),
    .tx_data(tx_data),
    .byte_sel(byte_sel),
    .grant(grant),
    .done(done),
    .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s t=%0t: got %0h expected %0h",
               nm, $time, act, exp);
    end
  endtask

  typedef struct {
    logic [2:0]  idx;
    logic [31:0] data;
    logic [7:0]  exp_data;
    logic [2:0]  exp_sel;
  } dp_vec_t;

  dp_vec_t tbl[8];

  // Transaction-level reference: who owns the line and when the frame
  // ends, derived from the busy waveform the bench itself schedules.
  int cyc = 0;
  int own = -1;
  int last = 3;
  int next_ok = 0;
  int rise_at = 0;
  int fall_at = 0;
  int done_at = 0;
  int mode = 0;
  logic [3:0] req_fix = 4'b0000;
  bit clr_on_done = 1'b0;
  int d_min = 0, d_max = 0;
  int l_min = 1, l_max = 1;

  // Observations of the DUT for order/spacing checks.
  logic [3:0] dgq[$];
  logic [3:0] dq[$];
  int zlen[$];
  int zrun = 0;
  logic [3:0] pg = 4'b0000;

  function automatic int rr_pick(input logic [3:0] r,
                                 input int lst);
    for (int k = 1; k <= 4; k++) begin
      if (r[(lst + k) % 4]) return (lst + k) % 4;
    end
    return -1;
  endfunction

  task automatic step();
    logic [3:0] eg, ed;
    logic       et;
    logic [7:0] ev;
    @(negedge clk);
    cyc++;
    ed = 4'b0000;
    if (own >= 0 && cyc == done_at) begin
      ed = 4'(1 << own);
      own = -1;
      // GAP cycles (done cycle is the first) plus one IDLE cycle.
      next_ok = cyc + GAP + 1;
    end else if (own < 0 && cyc >= next_ok && req != 0) begin
      own = rr_pick(req, last);
      last = own;
      rise_at = cyc + $urandom_range(d_max, d_min);
      fall_at = rise_at + $urandom_range(l_max, l_min);
      // Two sync flops plus the registered state change.
      done_at = fall_at + 3;
    end
    eg = 4'b0000;
    et = 1'b0;
    ev = 8'h00;
    if (own >= 0) begin
      eg = 4'(1 << own);
      et = 1'b1;
      ev = req_data[8*own +: 8];
    end
    chk("grant", grant, eg);
    chk("tx_rq", tx_rq, et);
    chk("done", done, ed);
    chk("err", err, 1'b0);
    chk("tx_data", tx_data, ev);
    chk("byte_sel", byte_sel, tx_byte_idx);
    if (grant != 0 && pg == 0) begin
      dgq.push_back(grant);
      if (zrun > 0) zlen.push_back(zrun);
    end
    if (grant == 0) zrun++;
    else zrun = 0;
    pg = grant;
    if (done != 0) dq.push_back(done);
    if (mode == 0) begin
      req = req & ~ed;
      if (own >= 0 && $urandom_range(31, 0) == 0)
        req[own] = 1'b0;
      for (int n = 0; n < 4; n++) begin
        if (n != own && !req[n] &&
            $urandom_range(7, 0) == 0)
          req[n] = 1'b1;
      end
    end else begin
      if (clr_on_done) req_fix = req_fix & ~ed;
      req = req_fix;
    end
    tx_busy = (own >= 0) && (cyc >= rise_at) &&
              (cyc < fall_at);
    req_data = $urandom;
    tx_byte_idx = 3'($urandom_range(7, 0));
  endtask

  task automatic rst_chk(input string nm);
    chk({nm, "_grant"}, grant, 4'b0000);
    chk({nm, "_tx_rq"}, tx_rq, 1'b0);
    chk({nm, "_done"}, done, 4'b0000);
    chk({nm, "_err"}, err, 1'b0);
    chk({nm, "_tx_data"}, tx_data, 8'h00);
  endtask

  task automatic hold_reset();
    reset = 1'b0;
    tx_busy = 1'b0;
    #1;
    rst_chk("rst_async");
    repeat (3) begin
      @(negedge clk);
      rst_chk("rst_hold");
    end
    reset = 1'b1;
    own = -1;
    last = 3;
    next_ok = 0;
    dgq.delete();
    dq.delete();
    zlen.delete();
    zrun = 0;
    pg = 4'b0000;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] exp_ord[5];
    int bad;
    tbl[0] = '{3'd0, 32'h01A00203, 8'hA0, 3'd0};
    tbl[1] = '{3'd1, 32'hFF5AFFFF, 8'h5A, 3'd1};
    tbl[2] = '{3'd2, 32'h00C30000, 8'hC3, 3'd2};
    tbl[3] = '{3'd3, 32'h12345678, 8'h34, 3'd3};
    tbl[4] = '{3'd4, 32'hDEADBEEF, 8'hAD, 3'd4};
    tbl[5] = '{3'd5, 32'h00FF0000, 8'hFF, 3'd5};
    tbl[6] = '{3'd6, 32'hFF00FFFF, 8'h00, 3'd6};
    tbl[7] = '{3'd7, 32'hCAFEF00D, 8'hFE, 3'd7};
    exp_ord[0] = 4'b0001;
    exp_ord[1] = 4'b0010;
    exp_ord[2] = 4'b0100;
    exp_ord[3] = 4'b1000;
    exp_ord[4] = 4'b0001;

    reset = 1'b1;
    req = 4'b0000;
    req_data = 32'h0;
    tx_busy = 1'b0;
    tx_byte_idx = 3'd0;
    #2;
    hold_reset();

    // Data path with requester 2 parked in START.
    req = 4'b0100;
    @(negedge clk);
    chk("dp_grant", grant, 4'b0100);
    for (int i = 0; i < 8; i++) begin
      req_data = tbl[i].data;
      tx_byte_idx = tbl[i].idx;
      #1;
      chk("dp_tx_data", tx_data, tbl[i].exp_data);
      chk("dp_byte_sel", byte_sel, tbl[i].exp_sel);
    end

    // Single requester, long busy, re-requesting after done.
    hold_reset();
    mode = 1;
    clr_on_done = 1'b0;
    req_fix = 4'b0010;
    d_min = 1; d_max = 1;
    l_min = 40; l_max = 40;
    req = req_fix;
    for (int n = 0; n < 400 && dgq.size() < 2; n++) step();
    chk("single_grants", dgq.size(), 2);
    if (dgq.size() >= 2) begin
      chk("single_g0", dgq[0], 4'b0010);
      chk("single_g1", dgq[1], 4'b0010);
      chk("single_dones", dq.size(), 1);
      chk("single_done_owner", dq[0], 4'b0010);
      // GAP_CYCLES of gap plus the IDLE arbitration cycle.
      chk("single_gap", zlen[0], GAP + 1);
    end

    // All four requesting continuously.
    hold_reset();
    mode = 1;
    clr_on_done = 1'b0;
    req_fix = 4'b1111;
    d_min = 1; d_max = 1;
    l_min = 5; l_max = 5;
    req = req_fix;
    for (int n = 0; n < 1000 && dgq.size() < 5; n++) step();
    chk("rr_grants", dgq.size(), 5);
    if (dgq.size() >= 5) begin
      for (int i = 0; i < 5; i++)
        chk("rr_order", dgq[i], exp_ord[i]);
      for (int i = 0; i < 4; i++)
        chk("rr_gap", zlen[i], GAP + 1);
    end

    // Reset in the middle of SEND.
    hold_reset();
    mode = 1;
    clr_on_done = 1'b1;
    req_fix = 4'b0100;
    d_min = 0; d_max = 0;
    l_min = 30; l_max = 30;
    req = req_fix;
    bad = 1;
    for (int n = 0; n < 100; n++) begin
      step();
      if (own >= 0 && cyc >= rise_at + 6) begin
        bad = 0;
        break;
      end
    end
    chk("midsend_reached", bad, 0);
    chk("midsend_tx_rq", tx_rq, 1'b1);
    req_fix = 4'b0101;
    req = req_fix;
    hold_reset();
    d_min = 0; d_max = 3;
    l_min = 2; l_max = 6;
    for (int n = 0; n < 400 && dgq.size() < 2; n++) step();
    chk("midsend_grants", dgq.size(), 2);
    if (dgq.size() >= 2) begin
      chk("midsend_first", dgq[0], 4'b0001);
      chk("midsend_second", dgq[1], 4'b0100);
    end

    // Randomized traffic against the reference.
    hold_reset();
    mode = 0;
    d_min = 0; d_max = 6;
    l_min = 1; l_max = 12;
    req = 4'b0000;
    for (int n = 0; n < 3000; n++) step();

    // START with the transmitter never going busy.
    hold_reset();
    req = 4'b1000;
    @(negedge clk);
    chk("to_grant", grant, 4'b1000);
    chk("to_tx_rq", tx_rq, 1'b1);
    bad = 0;
    for (int k = 1; k < TMO; k++) begin
      @(negedge clk);
      if (tx_rq !== 1'b1 || err !== 1'b0 ||
          done !== 4'b0000)
        bad++;
    end
    chk("to_wait_hold", bad, 0);
    @(negedge clk);
`ifdef RS485_TX_ARBITER_TIMEOUT_EN
    chk("to_fire_tx_rq", tx_rq, 1'b0);
    chk("to_fire_err", err, 1'b1);
    chk("to_fire_done", done, 4'b1000);
    chk("to_fire_grant", grant, 4'b0000);
    @(negedge clk);
    chk("to_after_err", err, 1'b0);
    chk("to_after_done", done, 4'b0000);
`else
    chk("to_none_tx_rq", tx_rq, 1'b1);
    chk("to_none_err", err, 1'b0);
    chk("to_none_grant", grant, 4'b1000);
    bad = 0;
    for (int k = 0; k < 45; k++) begin
      @(negedge clk);
      if (tx_rq !== 1'b1 || err !== 1'b0) bad++;
    end
    chk("to_none_hold", bad, 0);
`endif
    req = 4'b0000;
    hold_reset();

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
